// File: rtl/draw_pkg.sv
// Shared types and constants for the drawer -> VGA pixel path.
package draw_pkg;

    localparam int COORD_W  = 9;
    localparam int COLOUR_W = 9;

    localparam logic [COORD_W-1:0] SCREEN_W = 9'd320;
    localparam logic [COORD_W-1:0] SCREEN_H = 9'd240;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    localparam logic [1:0] FRAME_IDLE   = 2'd0;
    localparam logic [1:0] FRAME_DRAIN  = 2'd1;
    localparam logic [1:0] FRAME_SIGNAL = 2'd2;

    function automatic logic on_screen(input logic [COORD_W-1:0] px,
                                       input logic [COORD_W-1:0] py);
        return (px < SCREEN_W) && (py < SCREEN_H);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through pixel FIFO; head entry is always visible on dout.
module pixel_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  pixel_t                   din,
    output pixel_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    pixel_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pixel_plotter.sv
// Drawer-side pixel builder: position/colour latching, visibility filter,
// FIFO to the VGA adapter, and end-of-frame signalling once everything is out.
//
// state        | meaning
// FRAME_IDLE   | no frame end pending
// FRAME_DRAIN  | done seen, waiting for the FIFO to empty
// FRAME_SIGNAL | frame_done high for this one cycle
module pixel_plotter
    import draw_pkg::*;
#(
    parameter int                  DEPTH       = 4,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                ld_xy,
    input  logic                ld_pos,
    input  logic                ld_colour,
    input  logic                draw_pixel,
    input  logic                done,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic [COORD_W-1:0]  dx,
    input  logic [COORD_W-1:0]  dy,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                clear,
    output logic [COORD_W-1:0]  vga_x,
    output logic [COORD_W-1:0]  vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    input  logic                vga_ready,
    output logic                frame_done,
    output logic                overflow,
    output logic [15:0]         plotted
);

    logic [COORD_W-1:0]  base_x, base_y;
    logic [COORD_W-1:0]  pos_x, pos_y;
    logic                pos_off;
    logic [COLOUR_W-1:0] col;
    logic [COORD_W:0]    sum_x, sum_y;

    logic                visible, push_en, pop_en, drained;
    logic                fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    pixel_t              head;
    logic [1:0]          state, state_next;

    assign sum_x = {1'b0, base_x} + {1'b0, dx};
    assign sum_y = {1'b0, base_y} + {1'b0, dy};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            base_x  <= '0;
            base_y  <= '0;
            pos_x   <= '0;
            pos_y   <= '0;
            pos_off <= 1'b0;
            col     <= '0;
        end else begin
            if (ld_xy) begin
                base_x <= x;
                base_y <= y;
            end
            if (ld_pos) begin
                pos_x   <= sum_x[COORD_W-1:0];
                pos_y   <= sum_y[COORD_W-1:0];
                pos_off <= sum_x[COORD_W] | sum_y[COORD_W];
            end
            if (ld_colour) col <= colour;
        end
    end

    assign visible = draw_pixel && (col != TRANSPARENT) && !pos_off && on_screen(pos_x, pos_y);
    assign pop_en  = !fifo_empty && vga_ready;
    assign push_en = visible && (!fifo_full || pop_en);

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push_en),
        .pop    (pop_en),
        .din    ('{x: pos_x, y: pos_y, colour: col}),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Stale RAM contents are masked so the adapter sees zeros while idle.
    assign vga_plot   = !fifo_empty;
    assign vga_x      = fifo_empty ? '0 : head.x;
    assign vga_y      = fifo_empty ? '0 : head.y;
    assign vga_colour = fifo_empty ? '0 : head.colour;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
            plotted  <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            plotted  <= '0;
        end else begin
            if (visible && !push_en) overflow <= 1'b1;
            if (pop_en && (plotted != 16'hFFFF)) plotted <= plotted + 16'd1;
        end
    end

    assign drained = (fifo_count == '0) && !push_en;

    always_comb begin
        state_next = state;
        case (state)
            FRAME_IDLE:   if (done) state_next = drained ? FRAME_SIGNAL : FRAME_DRAIN;
            FRAME_DRAIN:  if (drained) state_next = FRAME_SIGNAL;
            FRAME_SIGNAL: state_next = FRAME_IDLE;
            default:      state_next = FRAME_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= FRAME_IDLE;
        else         state <= state_next;
    end

    assign frame_done = (state == FRAME_SIGNAL);

endmodule

// File: tb/tb_pixel_plotter.sv
// Self-checking bench for pixel_plotter: vector table plus scoreboard of expected plots.
module tb_pixel_plotter;
    import draw_pkg::*;

    logic       clock, resetn;
    logic       ld_xy, ld_pos, ld_colour, draw_pixel, done, clear, vga_ready;
    logic [8:0] x, y, dx, dy, colour;
    logic [8:0] vga_x, vga_y, vga_colour;
    logic       vga_plot, frame_done, overflow;
    logic [15:0] plotted;

    int checks = 0;
    int errors = 0;
    pixel_t sb[$];

    typedef struct {
        logic [8:0] x, y, dx, dy, colour;
        logic       pass;
    } vec_t;
    vec_t vecs[10];

    pixel_plotter #(.DEPTH(4), .TRANSPARENT(9'h1FF)) dut (
        .clock(clock), .resetn(resetn), .ld_xy(ld_xy), .ld_pos(ld_pos),
        .ld_colour(ld_colour), .draw_pixel(draw_pixel), .done(done),
        .x(x), .y(y), .dx(dx), .dy(dy), .colour(colour), .clear(clear),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .vga_ready(vga_ready), .frame_done(frame_done),
        .overflow(overflow), .plotted(plotted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Each accepted pixel is matched against the oldest expected entry.
    always @(negedge clock) begin
        if (resetn && vga_plot && vga_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_plot actual=(%0d,%0d,%0h) expected=none", vga_x, vga_y, vga_colour);
            end else begin
                pixel_t e;
                e = sb.pop_front();
                if ({vga_x, vga_y, vga_colour} !== e) begin
                    errors++;
                    $display("FAIL plot_data actual=(%0d,%0d,%0h) expected=(%0d,%0d,%0h)",
                             vga_x, vga_y, vga_colour, e.x, e.y, e.colour);
                end
            end
        end
    end

    task automatic send_pixel(input logic [8:0] px, input logic [8:0] py, input logic [8:0] pdx,
                              input logic [8:0] pdy, input logic [8:0] pcol, input logic exp_push);
        pixel_t e;
        ld_xy = 1'b1; x = px; y = py;
        tick();
        ld_xy = 1'b0; ld_pos = 1'b1; dx = pdx; dy = pdy; ld_colour = 1'b1; colour = pcol;
        tick();
        ld_pos = 1'b0; ld_colour = 1'b0; draw_pixel = 1'b1;
        if (exp_push) begin
            e.x = px + pdx; e.y = py + pdy; e.colour = pcol;
            sb.push_back(e);
        end
        tick();
        draw_pixel = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int fd_count, fd_cycle, last_pop, seen;
        pixel_t e;

        vecs[0] = '{9'd92,  9'd36,  9'd5,   9'd8,   9'h007, 1'b1};
        vecs[1] = '{9'd10,  9'd10,  9'd0,   9'd0,   9'h1FF, 1'b0};
        vecs[2] = '{9'd318, 9'd10,  9'd5,   9'd0,   9'h0AA, 1'b0};
        vecs[3] = '{9'd319, 9'd0,   9'd0,   9'd239, 9'h155, 1'b1};
        vecs[4] = '{9'd300, 9'd0,   9'd20,  9'd0,   9'h001, 1'b0};
        vecs[5] = '{9'd0,   9'd200, 9'd0,   9'd40,  9'h002, 1'b0};
        vecs[6] = '{9'd500, 9'd0,   9'd20,  9'd0,   9'h003, 1'b0};
        vecs[7] = '{9'd10,  9'd511, 9'd0,   9'd1,   9'h004, 1'b0};
        vecs[8] = '{9'd0,   9'd0,   9'd0,   9'd0,   9'h000, 1'b1};
        vecs[9] = '{9'd100, 9'd100, 9'd211, 9'd139, 9'h1FE, 1'b1};

        resetn = 1'b0; ld_xy = 0; ld_pos = 0; ld_colour = 0; draw_pixel = 0; done = 0;
        clear = 0; vga_ready = 0; x = 0; y = 0; dx = 0; dy = 0; colour = 0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {vga_plot, frame_done, overflow, plotted, vga_x, vga_y, vga_colour}, 0);
        @(negedge clock);
        resetn = 1'b1;
        tick();

        // Table: each vector is one complete pixel with the adapter always ready.
        vga_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            send_pixel(vecs[i].x, vecs[i].y, vecs[i].dx, vecs[i].dy, vecs[i].colour, vecs[i].pass);
            check($sformatf("vec%0d_plot", i), vga_plot, vecs[i].pass);
            if (vecs[i].pass) seen++;
        end
        drain(10);
        check("table_plotted", plotted, seen);
        check("table_overflow", overflow, 0);

        // Overflow: five visible pixels into a four-deep FIFO with the adapter stalled.
        pulse_clear();
        check("clear_plotted", plotted, 0);
        vga_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_pixel(9'(10 * i + 1), 9'(i + 2), 9'd0, 9'd0, 9'(i + 1), i < 4);
        end
        check("ovf_set", overflow, 1);
        e = sb[0];
        check("ovf_head", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, e});
        tick();
        tick();
        check("ovf_head_stable", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, e});
        vga_ready = 1'b1;
        drain(10);
        check("ovf_plotted", plotted, 4);
        check("ovf_sticky", overflow, 1);
        pulse_clear();
        check("ovf_clear", {overflow, plotted}, 0);

        // Frame end waits for the last queued pixel to leave.
        vga_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_pixel(9'(20 + i), 9'd30, 9'd1, 9'd1, 9'h0C0, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        fd_count = 0;
        for (int n = 0; n < 4; n++) begin
            if (frame_done) fd_count++;
            done = (n == 1);
            tick();
        end
        done = 1'b0;
        check("fd_held_while_stalled", fd_count, 0);
        vga_ready = 1'b1;
        fd_cycle = -1;
        last_pop = -1;
        for (int n = 0; n < 16; n++) begin
            if (vga_plot && vga_ready) last_pop = n;
            if (frame_done) begin
                fd_count++;
                fd_cycle = n;
            end
            tick();
        end
        check("fd_count", fd_count, 1);
        check("fd_after_last_pop", fd_cycle, last_pop + 2);

        done = 1'b1;
        tick();
        done = 1'b0;
        check("fd_empty_done", frame_done, 1);
        tick();
        check("fd_one_cycle", frame_done, 0);

        // Asynchronous reset while draining.
        vga_ready = 1'b0;
        send_pixel(9'd5, 9'd5, 9'd1, 9'd1, 9'h011, 1'b1);
        send_pixel(9'd6, 9'd6, 9'd1, 9'd1, 9'h022, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("pre_reset_plotted", plotted, 3);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs",
              {vga_plot, frame_done, overflow, plotted, vga_x, vga_y, vga_colour}, 0);
        sb.delete();
        @(negedge clock);
        resetn = 1'b1;
        tick();
        vga_ready = 1'b1;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            if (frame_done || vga_plot) seen++;
            tick();
        end
        check("post_reset_quiet", seen, 0);

        // draw_pixel uses the registered position; ld_pos with ld_xy uses the old base.
        ld_xy = 1'b1; x = 9'd50; y = 9'd50;
        tick();
        ld_xy = 1'b0; ld_pos = 1'b1; dx = 9'd1; dy = 9'd1; ld_colour = 1'b1; colour = 9'h0F0;
        tick();
        ld_colour = 1'b0;
        ld_xy = 1'b1; x = 9'd200; y = 9'd200; dx = 9'd10; dy = 9'd10; draw_pixel = 1'b1;
        e = '{x: 9'd51, y: 9'd51, colour: 9'h0F0};
        sb.push_back(e);
        tick();
        ld_xy = 1'b0; ld_pos = 1'b0;
        e = '{x: 9'd60, y: 9'd60, colour: 9'h0F0};
        sb.push_back(e);
        tick();
        draw_pixel = 1'b0; ld_pos = 1'b1; dx = 9'd2; dy = 9'd2;
        tick();
        ld_pos = 1'b0; draw_pixel = 1'b1;
        e = '{x: 9'd202, y: 9'd202, colour: 9'h0F0};
        sb.push_back(e);
        tick();
        draw_pixel = 1'b0;
        drain(10);
        check("final_plotted", plotted, 3);
        check("final_overflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
